// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the MM:SS stopwatch core.
// Also provides the load-saturation helper used by every digit.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_t;

  localparam bcd_t SEC_ONES_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_ONES_MAX = 4'd9;

  // A loaded digit above its limit is clamped to the limit.
  function automatic bcd_t bcd_sat(input bcd_t v, input bcd_t max);
    return (v > max) ? max : v;
  endfunction

endpackage

// File: rtl/stopwatch_digit.sv
// One BCD digit of the stopwatch chain: synchronous load with saturation,
// enable-gated up/down count, and a combinational terminal-count flag.
module stopwatch_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic [3:0] max,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       tc
);

  // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 4'd0;
    end else if (load) begin
      q <= bcd_sat(load_val, max);
    end else if (en) begin
      if (up) q <= (q >= max) ? 4'd0 : q + 4'd1;
      else    q <= (q == 4'd0) ? max : q - 4'd1;
    end
  end

  assign tc = up ? (q == max) : (q == 4'd0);

endmodule

// File: rtl/stopwatch_time_counter.sv
// MM:SS stopwatch core: IDLE/RUN/PAUSE/DONE control plus a four-digit BCD
// chain with terminal-count enables. Optional lap freeze: STOPWATCH_LAP_EN.
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int MIN_TENS_MAX = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        lap,
  output logic [15:0] digits,
  output logic        running,
  output logic        done,
  output logic        wrap
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_PAUSE = PAUSE;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [3:0] MIN_TENS_LIM = 4'(MIN_TENS_MAX);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [15:0] live;
  logic [15:0] dig_ld_val;
  logic        dig_load;
  logic        load_eff;
  logic        cnt_en;
  logic        count_zero;
  logic        last_down;
  logic [3:0]  q0, q1, q2, q3;
  logic        tc0, tc1, tc2, tc3;
  logic        en0, en1, en2, en3;

  // Load is refused while running; clear reuses the load path with zeros.
  assign load_eff   = load & (state != S_RUN) & ~clear;
  assign dig_load   = clear | load_eff;
  assign dig_ld_val = clear ? 16'h0000 : load_val;

  assign cnt_en = tick & (state == S_RUN) & ~stop & ~clear;
  assign en0    = cnt_en;
  assign en1    = en0 & tc0;
  assign en2    = en1 & tc1;
  assign en3    = en2 & tc2;

  assign live       = {q3, q2, q1, q0};
  assign count_zero = (live == 16'h0000);
  assign last_down  = ~up & (live == 16'h0001);

  stopwatch_digit u_sec_ones (
    .clk(clk), .rst(rst), .en(en0), .up(up), .max(SEC_ONES_MAX),
    .load(dig_load), .load_val(dig_ld_val[3:0]), .q(q0), .tc(tc0)
  );

  stopwatch_digit u_sec_tens (
    .clk(clk), .rst(rst), .en(en1), .up(up), .max(SEC_TENS_MAX),
    .load(dig_load), .load_val(dig_ld_val[7:4]), .q(q1), .tc(tc1)
  );

  stopwatch_digit u_min_ones (
    .clk(clk), .rst(rst), .en(en2), .up(up), .max(MIN_ONES_MAX),
    .load(dig_load), .load_val(dig_ld_val[11:8]), .q(q2), .tc(tc2)
  );

  stopwatch_digit u_min_tens (
    .clk(clk), .rst(rst), .en(en3), .up(up), .max(MIN_TENS_LIM),
    .load(dig_load), .load_val(dig_ld_val[15:12]), .q(q3), .tc(tc3)
  );

  // NOTE: state_next gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = S_IDLE;
    end else if (load_eff) begin
      if (state == S_DONE) state_next = S_PAUSE;
    end else if (stop) begin
      if (state == S_RUN) state_next = S_PAUSE;
    end else if (start) begin
      case (state)
        S_IDLE, S_PAUSE: state_next = (!up && count_zero) ? S_DONE : S_RUN;
        S_DONE:          if (up) state_next = S_RUN;
        default:         ;
      endcase
    end
    if (cnt_en && last_down) state_next = S_DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      wrap  <= 1'b0;
    end else begin
      state <= state_next;
      wrap  <= cnt_en & up & tc0 & tc1 & tc2 & tc3;
    end
  end

  assign running = (state == S_RUN);
  assign done    = (state == S_DONE);

`ifdef STOPWATCH_LAP_EN
  logic        lap_hold;
  logic [15:0] lap_val;

  // Any exit from RUN (including clear) drops the freeze.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_hold <= 1'b0;
      lap_val  <= 16'h0000;
    end else if (state != S_RUN || state_next != S_RUN) begin
      lap_hold <= 1'b0;
    end else if (lap) begin
      lap_hold <= ~lap_hold;
      if (!lap_hold) lap_val <= live;
    end
  end

  assign digits = lap_hold ? lap_val : live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign digits     = live;
`endif

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Scoreboard bench for stopwatch_time_counter: a seconds-based reference
// model pushes expected outputs, a monitor pops and compares every cycle.
module tb_stopwatch_time_counter;

  localparam int MTM       = 5;
  localparam int MAX_TOTAL = (MTM * 10 + 9) * 60 + 59;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct packed {
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic        wrap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic        up = 1'b1, load = 1'b0, lap = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [15:0] digits;
  logic        running, done, wrap;

  stopwatch_time_counter #(.MIN_TENS_MAX(MTM)) dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop),
    .clear(clear), .up(up), .load(load), .load_val(load_val), .lap(lap),
    .digits(digits), .running(running), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cycle  = 0;
  exp_t sb_q[$];
  logic set_up  = 1'b1;
  logic set_rst = 1'b1;

  int m_total = 0;
  int m_st = M_IDLE;
  int m_lap_total = 0;
  bit m_hold = 1'b0;
  bit m_wrap = 1'b0;

  function automatic int clamp(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic int to_total(input logic [15:0] v);
    int mt, mo, st, so;
    mt = clamp(int'(v[15:12]), MTM);
    mo = clamp(int'(v[11:8]), 9);
    st = clamp(int'(v[7:4]), 5);
    so = clamp(int'(v[3:0]), 9);
    return (mt * 10 + mo) * 60 + st * 10 + so;
  endfunction

  function automatic logic [15:0] to_bcd(input int t);
    int m, s;
    m = t / 60;
    s = t % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, n_cycle, act, exp);
    end
  endtask

  task automatic model_step();
    int prev_st, snap;
    bit counted;
    m_wrap = 1'b0;
    if (rst) begin
      m_total = 0;
      m_st    = M_IDLE;
      m_hold  = 1'b0;
      return;
    end
    prev_st = m_st;
    snap    = m_total;
    counted = tick && (m_st == M_RUN) && !stop && !clear;
    if (clear) begin
      m_total = 0;
      m_st    = M_IDLE;
    end else if (load && m_st != M_RUN) begin
      m_total = to_total(load_val);
      if (m_st == M_DONE) m_st = M_PAUSE;
    end else if (stop) begin
      if (m_st == M_RUN) m_st = M_PAUSE;
    end else if (start) begin
      if (m_st == M_IDLE || m_st == M_PAUSE) m_st = (!up && m_total == 0) ? M_DONE : M_RUN;
      else if (m_st == M_DONE && up) m_st = M_RUN;
    end
    if (counted) begin
      if (up) begin
        if (m_total == MAX_TOTAL) begin
          m_total = 0;
          m_wrap  = 1'b1;
        end else begin
          m_total++;
        end
      end else begin
        m_total = (m_total == 0) ? MAX_TOTAL : m_total - 1;
        if (m_total == 0) m_st = M_DONE;
      end
    end
`ifdef STOPWATCH_LAP_EN
    if (prev_st != M_RUN || m_st != M_RUN) begin
      m_hold = 1'b0;
    end else if (lap) begin
      if (!m_hold) m_lap_total = snap;
      m_hold = !m_hold;
    end
`else
    if (prev_st == snap) m_hold = 1'b0;
    m_hold = 1'b0;
`endif
  endtask

  task automatic cyc(input logic t, input logic s, input logic p, input logic c,
                     input logic l, input logic [15:0] lv, input logic lp);
    exp_t e;
    @(negedge clk);
    rst = set_rst; up = set_up;
    tick = t; start = s; stop = p; clear = c; load = l; load_val = lv; lap = lp;
    model_step();
    e.digits  = m_hold ? to_bcd(m_lap_total) : to_bcd(m_total);
    e.running = (m_st == M_RUN);
    e.done    = (m_st == M_DONE);
    e.wrap    = m_wrap;
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 16'h0000, 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 16'h0000, 0);
  endtask

  task automatic do_start();               cyc(0, 1, 0, 0, 0, 16'h0000, 0); endtask
  task automatic do_stop();                cyc(0, 0, 1, 0, 0, 16'h0000, 0); endtask
  task automatic do_clear();               cyc(0, 0, 0, 1, 0, 16'h0000, 0); endtask
  task automatic do_load(input logic [15:0] v); cyc(0, 0, 0, 0, 1, v, 0); endtask
  task automatic do_lap();                 cyc(0, 0, 0, 0, 0, 16'h0000, 1); endtask

  // Monitor: every registered output is compared one edge after its stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      n_cycle++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("digits",  digits,       e.digits);
        check("running", 16'(running), 16'(e.running));
        check("done",    16'(done),    16'(e.done));
        check("wrap",    16'(wrap),    16'(e.wrap));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_rst = 1'b1; set_up = 1'b1;
    idle(2);
    set_rst = 1'b0;
    idle(1);
    do_start(); ticks(10); idle(2);

    do_clear(); do_load(16'h5958); do_start(); ticks(2); idle(2); ticks(3);

    do_clear(); do_load(16'h0100); set_up = 1'b0; do_start();
    ticks(60); ticks(3); idle(1);
    do_start(); set_up = 1'b1; do_start(); ticks(2);

    cyc(1, 0, 1, 0, 0, 16'h0000, 0);
    do_load(16'h1234); do_start();
    cyc(1, 0, 0, 0, 1, 16'h4321, 0);
    do_stop(); do_load(16'h7A6B); idle(1);
    cyc(0, 1, 0, 1, 1, 16'h1234, 0); idle(2);

    set_up = 1'b0; do_start(); do_load(16'h0003); do_start(); ticks(4);

    set_up = 1'b1; do_clear(); do_start(); ticks(5);
    do_lap(); ticks(5); do_lap(); idle(1); ticks(2);
    do_lap(); ticks(1); do_stop(); idle(1);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic t;
      logic [15:0] lv;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) set_up = ~set_up;
      set_rst = (r == 99);
      t  = ($urandom_range(0, 9) < 6);
      lv = ($urandom_range(0, 1) == 1) ? 16'($urandom) : {12'h000, 4'($urandom_range(0, 3))};
      cyc(t, r >= 55 && r < 67, r >= 67 && r < 72, r >= 72 && r < 74,
          r >= 74 && r < 80, lv, r >= 80 && r < 86);
    end
    set_rst = 1'b0;
    idle(2);

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
